// File: rtl/snake_game_pkg.sv
// snake_game_pkg: shared encodings, FSM state type and score helpers for the snake turn scheduler
package snake_game_pkg;
  localparam int SCORE_W = 8;
  localparam logic [1:0] ST_START = 2'b00, ST_PLAY = 2'b01, ST_TURN_END = 2'b10, ST_GAME_OVER = 2'b11;
  localparam logic [1:0] TEAM_NONE = 2'b00, TEAM_1 = 2'b01, TEAM_2 = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_COUNTDOWN, S_PLAY, S_TURN_END, S_SWITCH, S_DONE} state_t;
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction
  function automatic logic [1:0] status_of(input state_t s);
    return s == S_IDLE ? ST_START :
           (s == S_COUNTDOWN || s == S_PLAY) ? ST_PLAY :
           (s == S_TURN_END || s == S_SWITCH) ? ST_TURN_END : ST_GAME_OVER;
  endfunction
endpackage

// File: rtl/snake_turn_scheduler_frame_tick_gen.sv
// frame_tick_gen: vsync falling-edge frame tick plus a clearable, saturating frame counter
module frame_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        clr,
  output logic        frame_tick,
  output logic [10:0] fcnt
);
  logic v0, v1;
  assign frame_tick = v1 & ~v0;
  always_ff @(posedge clk) begin
    if (rst) begin
      v0   <= 1'b1;
      v1   <= 1'b1;
      fcnt <= '0;
    end else begin
      v0   <= vsync;
      v1   <= v0;
      fcnt <= clr ? '0 : (frame_tick && fcnt != '1) ? fcnt + 11'd1 : fcnt;
    end
  end
endmodule

// File: rtl/snake_turn_scheduler.sv
// snake_turn_scheduler: two-team turn FSM with frame-aligned status and saturating scores
// Optional per-turn frame limit enabled by defining TURN_TIMEOUT_EN.
module snake_turn_scheduler
  import snake_game_pkg::*;
#(
  parameter int NUM_TURNS        = 3,
  parameter int COUNTDOWN_FRAMES = 120,
  parameter int HOLD_FRAMES      = 90,
  parameter int TURN_FRAMES      = 1800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vsync,
  input  logic                start_btn,
  input  logic                snake_dead,
  input  logic [SCORE_W-1:0]  run_score,
  output logic [1:0]          game_status,
  output logic [1:0]          current_team,
  output logic [SCORE_W-1:0]  team1_score,
  output logic [SCORE_W-1:0]  team2_score,
  output logic                game_complete,
  output logic                game_rst,
  output logic [6:0]          frames_left
);
  localparam int TW = $clog2(2 * NUM_TURNS + 1);
`ifdef TURN_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  state_t state, state_n;
  logic frame_tick, clr, start_q, turn_end;
  logic [10:0] fcnt;
  logic [TW-1:0] turn, turn_n;
  logic [1:0] team_n;
  logic [SCORE_W-1:0] s1_n, s2_n;
  frame_tick_gen u_ftg (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .clr        (clr),
    .frame_tick (frame_tick),
    .fcnt       (fcnt)
  );
  // a timeout coinciding with a death is still one turn end and one add
  assign turn_end = snake_dead | (TIMEOUT_EN && frame_tick && fcnt == 11'(TURN_FRAMES - 1));
  assign game_complete = state == S_DONE;
  assign frames_left = state == S_COUNTDOWN ? 7'(11'(COUNTDOWN_FRAMES) - fcnt) : '0;
  always_comb begin
    state_n = state;
    team_n  = current_team;
    s1_n    = team1_score;
    s2_n    = team2_score;
    turn_n  = turn;
    clr     = 1'b0;
    case (state)
      S_IDLE: if (start_btn) begin
        state_n = S_COUNTDOWN;
        team_n  = TEAM_1;
        s1_n    = '0;
        s2_n    = '0;
        turn_n  = '0;
        clr     = 1'b1;
      end
      S_COUNTDOWN: if (frame_tick && fcnt == 11'(COUNTDOWN_FRAMES - 1)) begin
        state_n = S_PLAY;
        clr     = 1'b1;
      end
      S_PLAY: if (turn_end) begin
        state_n = S_TURN_END;
        clr     = 1'b1;
        s1_n    = current_team == TEAM_1 ? sat_add(team1_score, run_score) : team1_score;
        s2_n    = current_team == TEAM_2 ? sat_add(team2_score, run_score) : team2_score;
      end
      S_TURN_END: if (frame_tick && fcnt == 11'(HOLD_FRAMES - 1)) state_n = S_SWITCH;
      S_SWITCH: begin
        turn_n  = turn + 1'b1;
        state_n = turn_n == TW'(2 * NUM_TURNS) ? S_DONE : S_COUNTDOWN;
        team_n  = turn_n == TW'(2 * NUM_TURNS) ? TEAM_NONE : (current_team == TEAM_1 ? TEAM_2 : TEAM_1);
        clr     = turn_n != TW'(2 * NUM_TURNS);
      end
      S_DONE: if (start_btn && !start_q) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      current_team <= TEAM_NONE;
      team1_score  <= '0;
      team2_score  <= '0;
      turn         <= '0;
      start_q      <= 1'b1;
      game_status  <= ST_START;
      game_rst     <= 1'b0;
    end else begin
      state        <= state_n;
      current_team <= team_n;
      team1_score  <= s1_n;
      team2_score  <= s2_n;
      turn         <= turn_n;
      start_q      <= start_btn;
      game_rst     <= state_n == S_COUNTDOWN && state != S_COUNTDOWN;
      if (frame_tick) game_status <= status_of(state);
    end
  end
endmodule
